// File: rtl/b12_pkg.sv
// Shared definitions for the b12 tone/LED scheduler: sound codes, LED patterns,
// scheduler state encoding and the code-to-LED decode.
package b12_pkg;

    localparam int DUR_W_DEF = 6;

    localparam logic [2:0] S_RED    = 3'd0;
    localparam logic [2:0] S_GREEN  = 3'd1;
    localparam logic [2:0] S_YELLOW = 3'd2;
    localparam logic [2:0] S_BLUE   = 3'd3;
    localparam logic [2:0] S_WIN    = 3'd4;
    localparam logic [2:0] S_LOSS   = 3'd5;

    localparam logic [3:0] LED_ON  = 4'b1111;
    localparam logic [3:0] LED_OFF = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } sched_state_t;

    // Colour codes light their own LED, WIN lights all, LOSS and the unused codes stay dark.
    function automatic logic [3:0] led_decode(input logic [2:0] code);
        logic [3:0] led;
        led = LED_OFF;
        case (code)
            S_RED:    led = 4'b0001;
            S_GREEN:  led = 4'b0010;
            S_YELLOW: led = 4'b0100;
            S_BLUE:   led = 4'b1000;
            S_WIN:    led = LED_ON;
            default:  led = LED_OFF;
        endcase
        return led;
    endfunction

    function automatic logic code_audible(input logic [2:0] code);
        return (code <= S_LOSS);
    endfunction

endpackage

// File: rtl/b12_dur_timer.sv
// Down-counter used for both the on-time and the off-time of a note.
// Load wins over decrement; the count never wraps below zero.
module b12_dur_timer #(
    parameter int DUR_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [DUR_W-1:0] load_val,
    output logic             zero,
    output logic [DUR_W-1:0] count
);

    logic [DUR_W-1:0] cnt_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (dec && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign zero  = (cnt_reg == '0);
    assign count = cnt_reg;

endmodule

// File: rtl/b12_tone_sched.sv
// Two-requester note scheduler driving the b12 speaker tone generator and LED bank.
// A has priority unless B has been starved STARVE_MAX times in a row.
module b12_tone_sched
    import b12_pkg::*;
#(
    parameter int DUR_W      = DUR_W_DEF,
    parameter int STARVE_MAX = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             abort,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [2:0]       a_sound,
    input  logic [DUR_W-1:0] a_on,
    input  logic [DUR_W-1:0] a_off,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [2:0]       b_sound,
    input  logic [DUR_W-1:0] b_on,
    input  logic [DUR_W-1:0] b_off,
    output logic             play,
    output logic [2:0]       sound,
    output logic [3:0]       nl,
    output logic             busy,
    output logic             gnt_id,
    output logic             done
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    sched_state_t     state_reg, state_next;
    logic [2:0]       code_reg, code_next;
    logic [DUR_W-1:0] off_reg;
    logic [SW-1:0]    starve_reg;
    logic             play_reg, busy_reg, done_reg, gnt_id_reg;
    logic [3:0]       nl_reg;

    logic             idle, force_b, grant_a, grant_b, grant;
    logic             tmr_load, tmr_dec, tmr_zero;
    logic [DUR_W-1:0] tmr_val, tmr_count;

    assign idle    = (state_reg == ST_IDLE);
    assign force_b = b_valid && (starve_reg == STARVE_LIM);
    assign a_ready = idle && !abort && a_valid && !force_b;
    assign b_ready = idle && !abort && b_valid && (!a_valid || force_b);
    assign grant_a = a_ready;
    assign grant_b = b_ready;
    assign grant   = grant_a || grant_b;

    b12_dur_timer #(.DUR_W(DUR_W)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load),
        .dec      (tmr_dec),
        .load_val (tmr_val),
        .zero     (tmr_zero),
        .count    (tmr_count)
    );

    always_comb begin
        state_next = state_reg;
        tmr_load   = 1'b0;
        tmr_dec    = 1'b0;
        tmr_val    = off_reg;
        code_next  = code_reg;
        case (state_reg)
            ST_IDLE: begin
                if (grant) begin
                    state_next = ST_ON;
                    tmr_load   = 1'b1;
                    tmr_val    = grant_b ? b_on : a_on;
                    code_next  = grant_b ? b_sound : a_sound;
                end
            end
            ST_ON: begin
                if (tmr_zero) begin
                    state_next = ST_GAP;
                    tmr_load   = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_GAP: begin
                if (tmr_zero) begin
                    state_next = ST_IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // Abort drops the note; the timer contents are irrelevant once back in IDLE.
        if (abort) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            code_reg   <= '0;
            off_reg    <= '0;
            starve_reg <= '0;
            gnt_id_reg <= 1'b0;
            play_reg   <= 1'b0;
            nl_reg     <= LED_OFF;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            code_reg  <= code_next;
            if (grant) begin
                off_reg    <= grant_b ? b_off : a_off;
                gnt_id_reg <= grant_b;
            end
            if (grant_b) begin
                starve_reg <= '0;
            end else if (grant_a && b_valid && (starve_reg != STARVE_LIM)) begin
                starve_reg <= starve_reg + 1'b1;
            end
            play_reg <= (state_next == ST_ON) && code_audible(code_next);
            nl_reg   <= (state_next == ST_ON) ? led_decode(code_next) : LED_OFF;
            busy_reg <= (state_next != ST_IDLE);
            done_reg <= (state_reg == ST_GAP) && tmr_zero && !abort;
        end
    end

    assign play   = play_reg;
    assign sound  = code_reg;
    assign nl     = nl_reg;
    assign busy   = busy_reg;
    assign gnt_id = gnt_id_reg;
    assign done   = done_reg;

endmodule
